p_mul_pow2_seq: RTL and testbench
=================================

# p_mul_pow2_seq

Sequential, bit-serial multiply-by-power-of-two that reverses `p_div_pow2` in floor mode. It rebuilds `out = in * 2^shamt + rem[shamt-1:0]` by shifting one bit per cycle and optionally saturates to the output precision. It sits downstream of quantized/scaled datapaths, where values divided for compact storage are restored to full scale. Both sides use valid/ready handshakes; one transaction is in flight at a time.

## Interface
- `MAX_SHIFT`, 8, largest supported shift; `SHW = $clog2(MAX_SHIFT+1)`.
- `SAT`, 1, 1: clamp to signed min/max on overflow; 0: wrap (keep low `O_CONF.prec` bits).
- `I_CONF`, `` `DEF_DCONF``, input dconf_t; `I_CONF.prec <= O_CONF.prec` required.
- `O_CONF`, `` `DEF_DCONF``, output dconf_t; `O_CONF.prec >= 2`.
- `clk`  in  1  clock (only clock domain).
- `reset_`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in`  in  `I_CONF.prec`  signed operand (INT or FXP; same bit handling for both).
- `rem`  in  `MAX_SHIFT`  unsigned remainder; only bits `[shamt-1:0]` are used.
- `shamt`  in  `SHW`  shift amount; values above `MAX_SHIFT` are clamped to `MAX_SHIFT`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  `O_CONF.prec`  signed result.
- `ovf`  out  1  overflow occurred for this result (valid with `out_valid`).

## Operation
- Data types:
  - INT and FXP are handled identically.
  - BOOL instance: `out` is tied to 0, `ovf` to 0; the handshake still works with shamt treated as 0.
  - FP is not supported; elaboration must fail with `$error`.
- FSM states: IDLE, BUSY, DONE. `in_ready = (state == IDLE)`.
- IDLE, on `in_valid && in_ready`:
  - `acc <= sign-extend(in)` to `O_CONF.prec`.
  - `cnt <= min(shamt, MAX_SHIFT)`.
  - `rsr <= rem << (MAX_SHIFT - cnt)`, which places the used bits at the MSB.
  - Clear sticky `ov`; latch `sgn = in[MSB]`.
  - Next state is BUSY if `cnt != 0`, else DONE.
- BUSY, each cycle:
  - If `acc[P-1] != acc[P-2]`, set `ov` (P = `O_CONF.prec`).
  - `acc <= {acc[P-2:0], rsr[MAX_SHIFT-1]}`; `rsr <= rsr << 1`; `cnt <= cnt - 1`.
  - When `cnt == 1`, go to DONE.
- Entering DONE, register the outputs:
  - `out` = `acc` if `!ov || !SAT`.
  - Otherwise `out` = `sgn ? {1'b1, {P-1{1'b0}}} : {1'b0, {P-1{1'b1}}}`.
  - `ovf` = `ov`; `out_valid` = 1.
- DONE: hold `out`, `ovf` and `out_valid` stable until `out_ready`, then go to IDLE and clear `out_valid`. `out` keeps its last value.
- Remainder bits are appended MSB-first, so the result equals `in*2^s + rem[s-1:0]`. This is the exact inverse of floor-mode `p_div_pow2` when no overflow occurs.
- `in_valid` outside IDLE is ignored; the producer must hold its request until `in_ready`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out` 0, `ovf` 0. Internal `acc`, `rsr`, `cnt`, `ov` are all 0.
- `reset_` asserted mid-BUSY or mid-DONE aborts the transaction immediately. No `out_valid` is produced for it.
- Latency is accept edge to `out_valid` high, counted in `clk` edges:
  - shamt = 0: 1 cycle.
  - shamt = n: n + 1 cycles.
- `out_valid && out_ready` handshake at edge k: `in_ready` is high in cycle k+1, and the next accept can occur at edge k+1.
- Minimum period per transaction: n + 2 cycles.
- `out_ready` high on the same cycle `out_valid` rises completes the transfer at that edge.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` depends only on state.

## Test plan
All cases use `I_CONF.prec = O_CONF.prec = 8`, `MAX_SHIFT = 8`.
- in=5, shamt=2, rem=0x03 -> out=23 (0x17), ovf=0, `out_valid` 3 edges after accept; rem bits above bit 1 set -> same result.
- in=-3 (0xFD), shamt=3, rem=0x05 -> out=-19 (0xED), ovf=0; then feed to `p_div_pow2` (SHIFT=3, ROUND=0) -> out=-3, rem=5.
- in=40, shamt=2 -> SAT=1: out=127 (0x7F), ovf=1; SAT=0: out=0xA0, ovf=1. in=-100, shamt=1, SAT=1 -> out=-128 (0x80), ovf=1.
- shamt=0, in=7 -> out=7 after 1 edge. Hold `out_ready`=0 for 4 cycles with `in_valid`=1, in=9 -> out stays 7, `in_ready`=0, the second request is not taken until the handshake, then in=9 gives out=9.
- shamt=12 (clamped to 8), in=0, rem=0xA5 -> out=0xA5 treated as signed (-91). ovf=1 because sign bit changed (SAT=1 -> out=0x7F), checked against the model.
- Assert `reset_` during the 2nd BUSY cycle of shamt=5 -> `out_valid` never rises, `in_ready`=1 after reset. The next request (in=1, shamt=1, rem=1) -> out=3.

Source files
------------

// File: rtl/p_mul_pow2_seq.sv
// p_mul_pow2_seq: bit-serial rebuild of out = in*2^shamt + rem[shamt-1:0], optional saturation.
// Latency: 1 edge for shamt=0, shamt+1 edges otherwise (accept edge counted); one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.

package p_mul_pow2_seq_pkg;
  typedef enum logic [1:0] {DT_BOOL, DT_INT, DT_FXP, DT_FP} dtype_e;
  typedef struct packed {
    dtype_e     dtype;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;
  localparam dconf_t DEF_DCONF = '{dtype: DT_INT, prec: 8'd8, frac: 8'd0};
endpackage

module p_mul_pow2_seq
  import p_mul_pow2_seq_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = 8,
  localparam int unsigned SHW = $clog2(MAX_SHIFT + 1),
  parameter bit          SAT       = 1'b1,
  parameter dconf_t      I_CONF    = DEF_DCONF,
  parameter dconf_t      O_CONF    = DEF_DCONF
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_CONF.prec-1:0] in,
  input  logic [MAX_SHIFT-1:0]   rem,
  input  logic [SHW-1:0]         shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_CONF.prec-1:0] out,
  output logic                   ovf
);

  localparam int P  = int'(O_CONF.prec);
  localparam int IP = int'(I_CONF.prec);
  localparam bit IS_BOOL = (I_CONF.dtype == DT_BOOL) || (O_CONF.dtype == DT_BOOL);
  localparam logic [SHW-1:0] SHMAX   = SHW'(MAX_SHIFT);
  localparam logic [P-1:0]   POS_MAX = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0]   NEG_MIN = {1'b1, {(P-1){1'b0}}};

  // Configurations this datapath cannot represent are rejected at elaboration.
  if (I_CONF.dtype == DT_FP || O_CONF.dtype == DT_FP) begin : g_fp_err
    $error("p_mul_pow2_seq: floating-point configurations are not supported");
  end
  if (P < 2) begin : g_prec_err
    $error("p_mul_pow2_seq: output precision must be at least 2");
  end
  if (IP > P) begin : g_width_err
    $error("p_mul_pow2_seq: input precision must not exceed output precision");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [P-1:0]         acc_q, acc_d;
  logic [MAX_SHIFT-1:0] rsr_q, rsr_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic                 ov_q, ov_d;
  logic                 sgn_q, sgn_d;
  logic [P-1:0]         out_q, out_d;
  logic                 ovf_q, ovf_d;

  logic [SHW-1:0] shamt_eff;
  logic [P-1:0]   acc_init;
  logic [P-1:0]   acc_shl;
  logic           ov_step;

  // BOOL instances never shift; oversized shifts clamp to the register depth.
  assign shamt_eff = IS_BOOL ? '0 : ((shamt > SHMAX) ? SHMAX : shamt);
  assign acc_init  = P'($signed(in));
  // One step: append the next remainder bit (MSB-first) below the shifted accumulator.
  assign acc_shl   = {acc_q[P-2:0], rsr_q[MAX_SHIFT-1]};
  // A step overflows when the bit about to become the sign differs from the sign.
  assign ov_step   = ov_q | (acc_q[P-1] ^ acc_q[P-2]);

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = (shamt_eff != '0) ? S_BUSY : S_DONE;
      S_BUSY:  if (cnt_q == SHW'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out       = out_q;
    ovf       = ovf_q;
  end

  // Datapath next-state: load on accept, shift while busy, register result on entering DONE.
  always_comb begin
    acc_d = acc_q;
    rsr_d = rsr_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;
    sgn_d = sgn_q;
    out_d = out_q;
    ovf_d = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d = acc_init;
          cnt_d = shamt_eff;
          rsr_d = rem << (SHMAX - shamt_eff);
          ov_d  = 1'b0;
          sgn_d = in[IP-1];
          if (shamt_eff == '0) begin
            out_d = IS_BOOL ? '0 : acc_init;
            ovf_d = 1'b0;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_shl;
        rsr_d = rsr_q << 1;
        cnt_d = cnt_q - SHW'(1);
        ov_d  = ov_step;
        if (cnt_q == SHW'(1)) begin
          ovf_d = ov_step;
          out_d = (ov_step && SAT) ? (sgn_q ? NEG_MIN : POS_MAX) : acc_shl;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      acc_q <= '0;
      rsr_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      sgn_q <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rsr_q <= rsr_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      sgn_q <= sgn_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_p_mul_pow2_seq.sv
// tb_p_mul_pow2_seq: directed vectors into a saturating and a wrapping instance in lockstep.
// Expected results are queued at issue time and popped by per-instance monitors.
// Latency, hold-under-backpressure and reset-abort behaviour are checked inline.
module tb_p_mul_pow2_seq;
  import p_mul_pow2_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_;
  logic       in_valid;
  logic [7:0] in_d;
  logic [7:0] rem;
  logic [3:0] shamt;
  logic       out_ready;

  logic       s_in_ready, s_out_valid, s_ovf;
  logic [7:0] s_out;
  logic       w_in_ready, w_out_valid, w_ovf;
  logic [7:0] w_out;

  always #5 clk = ~clk;

  p_mul_pow2_seq #(.MAX_SHIFT(8), .SAT(1'b1), .I_CONF(DEF_DCONF), .O_CONF(DEF_DCONF)) u_sat (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(s_in_ready),
    .in(in_d), .rem(rem), .shamt(shamt), .out_valid(s_out_valid),
    .out_ready(out_ready), .out(s_out), .ovf(s_ovf)
  );

  p_mul_pow2_seq #(.MAX_SHIFT(8), .SAT(1'b0), .I_CONF(DEF_DCONF), .O_CONF(DEF_DCONF)) u_wrap (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(w_in_ready),
    .in(in_d), .rem(rem), .shamt(shamt), .out_valid(w_out_valid),
    .out_ready(out_ready), .out(w_out), .ovf(w_ovf)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] in;
    logic [7:0] rem;
    logic [3:0] sh;
    logic [7:0] so;   // expected out, saturating
    logic       sv;   // expected ovf, saturating
    logic [7:0] wo;   // expected out, wrapping
    logic       wv;   // expected ovf, wrapping
    int         lat;  // accept edge to out_valid, accept edge counted
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t q_sat[$];
  exp_t q_wrap[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a result is consumed on the cycle where valid and ready are both high.
  always @(negedge clk) begin : mon_sat
    exp_t e;
    if (reset_ && s_out_valid && out_ready) begin
      if (q_sat.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sat_unexpected_output actual=0x%0h expected=none", s_out);
      end else begin
        e = q_sat.pop_front();
        chk("sat_out", s_out, e.out);
        chk("sat_ovf", s_ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin : mon_wrap
    exp_t e;
    if (reset_ && w_out_valid && out_ready) begin
      if (q_wrap.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wrap_unexpected_output actual=0x%0h expected=none", w_out);
      end else begin
        e = q_wrap.pop_front();
        chk("wrap_out", w_out, e.out);
        chk("wrap_ovf", w_ovf, e.ovf);
      end
    end
  end

  // Waits for in_ready, presents the request for exactly the accept edge.
  task automatic issue(input vec_t v, input bit push);
    int n;
    n = 0;
    while (!s_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", s_in_ready, 1);
    in_valid = 1'b1;
    in_d     = v.in;
    rem      = v.rem;
    shamt    = v.sh;
    if (push) begin
      q_sat.push_back('{out: v.so, ovf: v.sv});
      q_wrap.push_back('{out: v.wo, ovf: v.wv});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 1;
    while (!s_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("wrap_valid_lockstep", w_out_valid, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", s_in_ready, 1);
    chk("out_valid_cleared", s_out_valid, 0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   seen;

  initial begin
    //           in     rem    sh     sat out  ovf   wrap out ovf  lat
    vecs[0] = '{8'h05, 8'h03, 4'd2,  8'h17, 1'b0, 8'h17, 1'b0, 3};  // 5*4+3 = 23
    vecs[1] = '{8'h05, 8'hFF, 4'd2,  8'h17, 1'b0, 8'h17, 1'b0, 3};  // unused rem bits ignored
    vecs[2] = '{8'hFD, 8'h05, 4'd3,  8'hED, 1'b0, 8'hED, 1'b0, 4};  // -3*8+5 = -19
    vecs[3] = '{8'h28, 8'h00, 4'd2,  8'h7F, 1'b1, 8'hA0, 1'b1, 3};  // 160 > 127
    vecs[4] = '{8'h9C, 8'h00, 4'd1,  8'h80, 1'b1, 8'h38, 1'b1, 2};  // -200 < -128
    vecs[5] = '{8'h00, 8'hA5, 4'd12, 8'h7F, 1'b1, 8'hA5, 1'b1, 9};  // clamped to 8: 165 > 127
    vecs[6] = '{8'h3F, 8'h01, 4'd1,  8'h7F, 1'b0, 8'h7F, 1'b0, 2};  // exactly +127
    vecs[7] = '{8'hC0, 8'h00, 4'd1,  8'h80, 1'b0, 8'h80, 1'b0, 2};  // exactly -128

    reset_    = 1'b0;
    in_valid  = 1'b0;
    in_d      = '0;
    rem       = '0;
    shamt     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", s_in_ready, 1);
    chk("reset_out_valid", s_out_valid, 0);
    chk("reset_out", s_out, 8'h00);
    chk("reset_ovf", s_ovf, 0);
    chk("reset_wrap_out", w_out, 8'h00);
    reset_ = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], 1'b1);
      wait_out(vecs[i].lat);
      drain();
    end

    // shamt=0 result held under backpressure while a second request waits.
    v = '{8'h07, 8'h00, 4'd0, 8'h07, 1'b0, 8'h07, 1'b0, 1};
    issue(v, 1'b1);
    wait_out(1);
    in_valid = 1'b1;
    in_d     = 8'h09;
    rem      = 8'h00;
    shamt    = 4'd0;
    q_sat.push_back('{out: 8'h09, ovf: 1'b0});
    q_wrap.push_back('{out: 8'h09, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_out", s_out, 8'h07);
      chk("hold_in_ready", s_in_ready, 0);
      chk("hold_out_valid", s_out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_cycle_after_hs", s_in_ready, 1);
    chk("valid_low_cycle_after_hs", s_out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_request_accepted_next_edge", s_out_valid, 1);
    drain();

    // Reset asserted in the second BUSY cycle of a 5-step shift aborts it.
    v = '{8'h11, 8'h1F, 4'd5, 8'h00, 1'b0, 8'h00, 1'b0, 6};
    issue(v, 1'b0);
    @(posedge clk); #1;
    reset_ = 1'b0;
    #1;
    chk("abort_in_ready", s_in_ready, 1);
    chk("abort_out_valid", s_out_valid, 0);
    chk("abort_out", s_out, 8'h00);
    chk("abort_ovf", s_ovf, 0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_out_valid || w_out_valid) seen++;
    end
    chk("no_valid_after_abort", seen, 0);
    @(posedge clk); #1;

    v = '{8'h01, 8'h01, 4'd1, 8'h03, 1'b0, 8'h03, 1'b0, 2};
    issue(v, 1'b1);
    wait_out(2);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("sat_queue_drained", q_sat.size(), 0);
    chk("wrap_queue_drained", q_wrap.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
